rr_arb4: RTL and testbench
==========================

Name: rr_arb4

Overview:
- Four-requester round-robin arbiter with packet lock. It sits directly upstream of the team's 4:1 width-parameterised mux and drives that mux's 2-bit select.
- It also produces the handshake signals around the mux:
  - a valid/last toward the downstream consumer;
  - per-source ready back to the four producers.
- Once a source is granted, the grant is held until that source's packet completes. This guarantees the mux select is stable for the whole transfer.

Parameters:
- PKT_MODE, 1: 1 = hold grant until a handshaked beat with last[sel]=1; 0 = release after every handshaked beat (last ignored).
- RST_PTR, 0: initial round-robin pointer (0..3) loaded at reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  4  per-source valid/request, bit i = source i
- last  input  4  per-source end-of-packet flag, sampled only for the granted source
- out_ready  input  1  downstream ready
- sel  output  2  mux select (drives mux s input), registered
- gnt  output  4  one-hot grant, registered, equals 1<<sel while LOCKED, else 0
- out_valid  output  1  req[sel] while LOCKED, else 0 (combinational from registered state)
- out_last  output  1  last[sel] while LOCKED (forced 1 when PKT_MODE=0), else 0
- in_ready  output  4  bit i = out_ready while LOCKED and sel==i, else 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE, sel=0, gnt=0, ptr=RST_PTR;
  - hence out_valid=0, out_last=0, in_ready=0.
  - Reset asserted mid-packet aborts the grant immediately (asynchronous). There is no recovery of a partial packet.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register the winner into sel and gnt, and go to LOCKED on the next edge.
  - Arbitration latency: 1 cycle from req rise to gnt/out_valid.
- State LOCKED:
  - Beat handshake = out_valid & out_ready (equivalently req[sel] & in_ready[sel]).
  - If PKT_MODE=1, completion = handshake & last[sel].
  - If PKT_MODE=0, completion = handshake.
  - On completion: state→IDLE, gnt→0, ptr←sel+1 (mod 4, 3 wraps to 0). sel holds its value.
  - Without completion: stay LOCKED; sel and gnt unchanged.
  - If the granted source drops req mid-packet, out_valid=0 but the lock is retained. Other sources cannot pre-empt.
- Bubble: exactly one idle cycle between packets. After completion, gnt=0 for one cycle, then the next winner is granted.
- Fairness: a source that just completed has the lowest priority next round. Any continuously requesting source is granted within 4 arbitrations.
- Simultaneous events:
  - A req change on a non-granted source during LOCKED has no effect.
  - A req rise in the same cycle as completion is not seen until the IDLE cycle.
- last[i] for i≠sel is ignored.
- in_ready has no combinational dependence on req (no loop through producers). out_valid depends combinationally on req[sel] only.

Decomposition:
- Shared package: state enum (IDLE, LOCKED) and constant NUM_SRC=4.
- One natural sub-module: rr_pick4.
  - Combinational: req[3:0] and ptr[1:0] in, found and idx[1:0] out.
  - Reusable by future wider arbiters.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 → sel=0, gnt=0, out_valid=0, in_ready=0. Release; next edge → gnt=4'b0001 (RST_PTR=0).
- Single packet: req=4'b0100, 3-beat packet with last on beat 3, out_ready=1 → gnt=4'b0100 and sel=2 after 1 cycle. in_ready=4'b0100 for 3 cycles, then gnt=0 for 1 cycle; ptr=3.
- Round-robin rotation: req=4'b1111 held, 1-beat packets → grant order 0,1,2,3,0 with one bubble between each.
- Backpressure and lock: source 1 locked mid-packet, out_ready=0 for 5 cycles, then req raised on source 0 → sel stays 1, in_ready=0, no grant change. Release out_ready → packet finishes on source 1, then source 2.
- Wrap and dropout: ptr=3, req=4'b1001 → grant 3. Source 3 drops req for 2 cycles mid-packet → out_valid=0, gnt stays 4'b1000. After last, next grant=0.
- PKT_MODE=0: req=4'b0011, last held 0 → grants alternate 0,1,0,1 per handshaked beat, out_last=1 each beat.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// rtl/rr_arb4_pkg.sv - shared types and constants for the round-robin arbiter
package rr_arb4_pkg;

    localparam int NUM_SRC = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - first set request at or after ptr, wrapping mod 4
module rr_pick4
    import rr_arb4_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic               found,
    output logic [1:0]         idx
);

    // Scan highest offset first so the lowest offset from ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                found = 1'b1;
                idx   = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - 4-source round-robin arbiter holding the grant for a whole packet
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter bit         PKT_MODE = 1'b1,
    parameter logic [1:0] RST_PTR  = 2'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] last,
    input  logic               out_ready,
    output logic [1:0]         sel,
    output logic [NUM_SRC-1:0] gnt,
    output logic               out_valid,
    output logic               out_last,
    output logic [NUM_SRC-1:0] in_ready
);

    state_t     state;
    logic [1:0] ptr;
    logic       found;
    logic [1:0] idx;
    logic       locked;
    logic       done;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (idx)
    );

    assign locked    = (state == LOCKED);
    assign out_valid = locked & req[sel];
    assign out_last  = locked & (PKT_MODE ? last[sel] : 1'b1);
    // in_ready deliberately ignores req so producers never see a loop.
    assign in_ready  = locked ? ({3'b000, out_ready} << sel) : '0;
    assign done      = out_valid & out_ready & out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 2'd0;
            gnt   <= '0;
            ptr   <= RST_PTR;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sel   <= idx;
                        gnt   <= 4'b0001 << idx;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (done) begin
                        state <= IDLE;
                        gnt   <= '0;
                        ptr   <= sel + 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb4.sv
// tb/tb_rr_arb4.sv - scoreboard bench for rr_arb4 in packet and per-beat modes
module tb_rr_arb4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req0, last0, req1, last1;
    logic       ordy0, ordy1;
    logic [1:0] sel0, sel1;
    logic [3:0] gnt0, gnt1, ir0, ir1;
    logic       ov0, ol0, ov1, ol1;

    int n_cmp = 0;
    int n_err = 0;
    int q0[$];
    int q1[$];
    logic [3:0] pg0 = 4'b0000;
    logic [3:0] pg1 = 4'b0000;

    rr_arb4 #(.PKT_MODE(1'b1), .RST_PTR(2'd0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .last(last0), .out_ready(ordy0),
        .sel(sel0), .gnt(gnt0), .out_valid(ov0), .out_last(ol0), .in_ready(ir0)
    );

    rr_arb4 #(.PKT_MODE(1'b0), .RST_PTR(2'd0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .last(last1), .out_ready(ordy1),
        .sel(sel1), .gnt(gnt1), .out_valid(ov1), .out_last(ol1), .in_ready(ir1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Grant-start monitors pop the expected winner when gnt leaves zero.
    always @(negedge clk) begin
        if (gnt0 != 4'b0000 && pg0 == 4'b0000) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_grant", gnt0, 0);
            end else begin
                int e;
                e = q0.pop_front();
                check("dut0_grant_sel", sel0, e);
                check("dut0_grant_onehot", gnt0, 4'b0001 << e);
            end
        end
        pg0 = gnt0;
    end

    always @(negedge clk) begin
        if (gnt1 != 4'b0000 && pg1 == 4'b0000) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_grant", gnt1, 0);
            end else begin
                int e;
                e = q1.pop_front();
                check("dut1_grant_sel", sel1, e);
                check("dut1_grant_onehot", gnt1, 4'b0001 << e);
            end
        end
        pg1 = gnt1;
    end

    initial begin
        rst_n = 1'b0;
        req0  = 4'b1111; last0 = 4'b1111; ordy0 = 1'b1;
        req1  = 4'b0000; last1 = 4'b0000; ordy1 = 1'b1;

        // N1: in reset with all requests high
        @(negedge clk);
        check("rst_sel", sel0, 0);
        check("rst_gnt", gnt0, 0);
        check("rst_out_valid", ov0, 0);
        check("rst_out_last", ol0, 0);
        check("rst_in_ready", ir0, 0);
        check("rst_gnt_mode0", gnt1, 0);
        rst_n = 1'b1;
        q0.push_back(0); q0.push_back(1); q0.push_back(2);
        q0.push_back(3); q0.push_back(0);

        // N2..N11: single-beat rotation with one bubble between grants
        for (int c = 2; c <= 11; c++) begin
            @(negedge clk);
            if (c % 2 == 1) check("rot_bubble", gnt0, 0);
            if (c == 2) begin
                check("first_in_ready", ir0, 4'b0001);
                check("first_out_last", ol0, 1);
            end
        end
        req0 = 4'b0000; last0 = 4'b0000;

        // N12: three-beat packet on source 2
        @(negedge clk);
        req0 = 4'b0100; q0.push_back(2);
        @(negedge clk);
        check("pkt_sel", sel0, 2);
        check("pkt_gnt", gnt0, 4'b0100);
        check("pkt_ready_b1", ir0, 4'b0100);
        @(negedge clk);
        check("pkt_ready_b2", ir0, 4'b0100);
        @(negedge clk);
        check("pkt_ready_b3", ir0, 4'b0100);
        last0 = 4'b0100;

        // N16: bubble after packet, then wrap from ptr=3
        @(negedge clk);
        check("pkt_bubble_gnt", gnt0, 0);
        check("pkt_bubble_valid", ov0, 0);
        req0 = 4'b1001; last0 = 4'b0000;
        q0.push_back(3); q0.push_back(0);
        @(negedge clk);
        check("wrap_gnt", gnt0, 4'b1000);
        check("wrap_valid", ov0, 1);
        @(negedge clk);
        req0 = 4'b0001;
        @(negedge clk);
        check("drop_valid_a", ov0, 0);
        check("drop_gnt_a", gnt0, 4'b1000);
        @(negedge clk);
        check("drop_valid_b", ov0, 0);
        check("drop_gnt_b", gnt0, 4'b1000);
        check("drop_sel", sel0, 3);
        req0 = 4'b1001; last0 = 4'b1000;
        @(negedge clk);
        check("wrap_bubble", gnt0, 0);
        req0 = 4'b0001; last0 = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        check("src0_done", gnt0, 0);

        // N23: backpressure lock on source 1
        req0 = 4'b0010; last0 = 4'b0000; q0.push_back(1);
        @(negedge clk);
        check("bp_gnt", gnt0, 4'b0010);
        @(negedge clk);
        ordy0 = 1'b0;
        for (int c = 26; c <= 30; c++) begin
            @(negedge clk);
            check("bp_in_ready", ir0, 0);
            check("bp_gnt_hold", gnt0, 4'b0010);
            check("bp_sel_hold", sel0, 1);
            check("bp_valid", ov0, 1);
            if (c == 26) req0 = 4'b0011;
            if (c == 27) req0 = 4'b0111;
        end
        ordy0 = 1'b1; last0 = 4'b0010; q0.push_back(2);
        @(negedge clk);
        check("bp_release_bubble", gnt0, 0);
        @(negedge clk);
        check("after_bp_sel", sel0, 2);
        req0 = 4'b0100; last0 = 4'b0100;
        @(negedge clk);
        check("after_bp_done", gnt0, 0);
        req0 = 4'b0000;

        // Per-beat mode: last ignored, grants alternate each handshaked beat
        @(negedge clk);
        req1 = 4'b0011; last1 = 4'b0000;
        q1.push_back(0); q1.push_back(1); q1.push_back(0); q1.push_back(1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                check("m0_out_last", ol1, 1);
                check("m0_out_valid", ov1, 1);
                check("m0_in_ready", ir1, (c % 4 == 0) ? 4'b0001 : 4'b0010);
            end else begin
                check("m0_bubble", gnt1, 0);
            end
        end
        req1 = 4'b0000;

        @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
